// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and table-check helpers for the Huffman decode path.
package huffman_pkg;

  localparam int NSYM   = 6;
  localparam int CODE_W = 8;
  localparam int SYM_W  = 3;
  localparam int LEN_W  = 4;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(CODE_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // A mask is usable when it is a nonzero run of ones starting at bit 0.
  function automatic logic mask_ok(input logic [CODE_W-1:0] m);
    logic [CODE_W-1:0] m_inc;
    m_inc = m + {{(CODE_W-1){1'b0}}, 1'b1};
    return (m != '0) && ((m & m_inc) == '0);
  endfunction

  function automatic logic [LEN_W-1:0] popcount(input logic [CODE_W-1:0] m);
    logic [LEN_W-1:0] n;
    n = '0;
    for (int i = 0; i < CODE_W; i++) begin
      n = n + {{(LEN_W-1){1'b0}}, m[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/huff_match.sv
// Combinational code-word matcher: finds the lowest-index table entry whose
// length and masked code equal the current accumulator contents.
module huff_match
  import huffman_pkg::*;
(
  input  logic [CODE_W-1:0]            acc_i,
  input  logic [LEN_W-1:0]             cnt_i,
  input  logic [NSYM-1:0][CODE_W-1:0]  hc_i,
  input  logic [NSYM-1:0][CODE_W-1:0]  m_i,
  input  logic [NSYM-1:0][LEN_W-1:0]   len_tbl_i,
  output logic                         hit_o,
  output logic [SYM_W-1:0]             hit_sym_o
);

  // Scan from the highest index down so the lowest matching index is left last.
  always_comb begin
    hit_o     = 1'b0;
    hit_sym_o = '0;
    for (int i = NSYM - 1; i >= 0; i--) begin
      if ((cnt_i == len_tbl_i[i]) && ((acc_i & m_i[i]) == hc_i[i])) begin
        hit_o     = 1'b1;
        hit_sym_o = SYM_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder: loads and validates a 6-entry code table,
// then shifts stream bits into an accumulator and emits symbols 1..6.
//   state | meaning
//   IDLE  | no table loaded, waiting for tbl_load
//   RUN   | table valid, accepting bits and emitting symbols
//   ERR   | bad table or undecodable stream, waiting for a valid tbl_load
module huffman_decoder
  import huffman_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tbl_load,
  input  logic [NSYM*CODE_W-1:0]   hc_tbl,
  input  logic [NSYM*CODE_W-1:0]   m_tbl,
  output logic                     tbl_ok,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  input  logic                     flush,
  output logic [SYM_W-1:0]         sym_out,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic                     dec_err
);

  state_e                       state_q, state_d;
  logic [NSYM-1:0][CODE_W-1:0]  hc_q, hc_d, m_q, m_d;
  logic [NSYM-1:0][LEN_W-1:0]   lt_q, lt_d;
  logic [CODE_W-1:0]            acc_q, acc_d, acc_nxt;
  logic [LEN_W-1:0]             len_q, len_d, len_nxt;
  logic [SYM_W-1:0]             sym_q, sym_d;
  logic                         sym_vld_q, sym_vld_d;
  logic [NSYM-1:0][CODE_W-1:0]  hc_in, m_in;
  logic                         tbl_valid, accept, hit;
  logic [SYM_W-1:0]             hit_sym;

  assign hc_in = hc_tbl;
  assign m_in  = m_tbl;

  always_comb begin
    tbl_valid = 1'b1;
    for (int i = 0; i < NSYM; i++) begin
      if (!mask_ok(m_in[i]) || ((hc_in[i] & ~m_in[i]) != '0)) tbl_valid = 1'b0;
    end
  end

  assign bit_ready = (state_q == ST_RUN) && !flush && (!sym_vld_q || sym_ready);
  assign accept    = bit_valid && bit_ready;
  assign acc_nxt   = {acc_q[CODE_W-2:0], bit_in};
  assign len_nxt   = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;

  huff_match u_match (
    .acc_i     (acc_nxt),
    .cnt_i     (len_nxt),
    .hc_i      (hc_q),
    .m_i       (m_q),
    .len_tbl_i (lt_q),
    .hit_o     (hit),
    .hit_sym_o (hit_sym)
  );

  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    m_d       = m_q;
    lt_d      = lt_q;
    acc_d     = acc_q;
    len_d     = len_q;
    sym_d     = sym_q;
    sym_vld_d = sym_vld_q;
    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (tbl_load) begin
          if (tbl_valid) begin
            hc_d      = hc_in;
            m_d       = m_in;
            for (int i = 0; i < NSYM; i++) lt_d[i] = popcount(m_in[i]);
            acc_d     = '0;
            len_d     = '0;
            sym_vld_d = 1'b0;
            state_d   = ST_RUN;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_RUN: begin
        if (sym_vld_q && sym_ready) sym_vld_d = 1'b0;
        if (flush) begin
          acc_d = '0;
          len_d = '0;
        end else if (accept) begin
          if (hit) begin
            sym_vld_d = 1'b1;
            sym_d     = hit_sym;
            acc_d     = '0;
            len_d     = '0;
          end else if (len_nxt == LEN_MAX) begin
            // A full-width word with no match can never decode; stop here.
            state_d   = ST_ERR;
            sym_vld_d = 1'b0;
            acc_d     = '0;
            len_d     = '0;
          end else begin
            acc_d = acc_nxt;
            len_d = len_nxt;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      hc_q      <= '0;
      m_q       <= '0;
      lt_q      <= '0;
      acc_q     <= '0;
      len_q     <= '0;
      sym_q     <= '0;
      sym_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hc_q      <= hc_d;
      m_q       <= m_d;
      lt_q      <= lt_d;
      acc_q     <= acc_d;
      len_q     <= len_d;
      sym_q     <= sym_d;
      sym_vld_q <= sym_vld_d;
    end
  end

  assign tbl_ok    = (state_q == ST_RUN);
  assign dec_err   = (state_q == ST_ERR);
  assign sym_valid = sym_vld_q;
  assign sym_out   = sym_q;

endmodule
